// File: rtl/res_fifo_gen_pkg.sv
// Shared defaults and helper types for the res_fifo_gen FIFO slice.
// RES_FIFO_PARITY_EN is undefined by default (no parity column, no parity_err port).
package res_fifo_gen_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_AE_LEVEL   = 4;

  // {write accepted, read accepted} selects how the occupancy count moves
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic int fifoDepth(input int addrWidth);
    return 1 << addrWidth;
  endfunction

endpackage

// File: rtl/res_fifo_gen_if.sv
// Handshake/status bundle of res_fifo_gen; parity_err exists only with RES_FIFO_PARITY_EN.
interface res_fifo_gen_if
  import res_fifo_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  flush;
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;
`ifdef RES_FIFO_PARITY_EN
  logic                  parity_err;
`endif

  modport master (
    output flush, din, wr_en, rd_en,
`ifdef RES_FIFO_PARITY_EN
    input  parity_err,
`endif
    input  dout, rd_valid, full, empty, almost_full, almost_empty,
    input  level, overflow, underflow
  );

  modport slave (
    input  flush, din, wr_en, rd_en,
`ifdef RES_FIFO_PARITY_EN
    output parity_err,
`endif
    output dout, rd_valid, full, empty, almost_full, almost_empty,
    output level, overflow, underflow
  );

endinterface

// File: rtl/res_fifo_gen_mem.sv
// res_fifo_mem: simple dual-port RAM, synchronous read, read-old-data on collision.
// No reset, so a hard SRAM macro with the same ports can replace it.
module res_fifo_mem #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  i_wrEn,
  input  logic [ADDR_WIDTH-1:0] i_wrAddr,
  input  logic [WIDTH-1:0]      i_wrData,
  input  logic                  i_rdEn,
  input  logic [ADDR_WIDTH-1:0] i_rdAddr,
  output logic [WIDTH-1:0]      o_rdData
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [WIDTH-1:0] r_rdData;

  // Both ports in one non-blocking block: a same-address read sees the old word
  always_ff @(posedge clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
    if (i_rdEn) r_rdData <= r_mem[i_rdAddr];
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/res_fifo_gen.sv
// res_fifo_gen: synchronous FIFO with sticky overflow/underflow and 1-cycle read latency.
// Optional RES_FIFO_PARITY_EN adds a stored even-parity bit and the parity_err output.
module res_fifo_gen
  import res_fifo_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = fifoDepth(ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
  input logic           clk,
  input logic           rst_n,
  res_fifo_gen_if.slave bus
);

`ifdef RES_FIFO_PARITY_EN
  localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
  localparam int MEM_WIDTH = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(fifoDepth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = (ADDR_WIDTH)'(1);

  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_rdValid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rdAcc;
  logic                  w_wrAcc;
  fifo_op_e              w_op;
  logic [MEM_WIDTH-1:0]  w_memWrData;
  logic [MEM_WIDTH-1:0]  w_memRdData;

  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);

  // A same-cycle write never makes an empty FIFO readable; a read frees a full one
  assign w_rdAcc = bus.rd_en & ~w_empty & ~bus.flush;
  assign w_wrAcc = bus.wr_en & (~w_full | w_rdAcc) & ~bus.flush;
  assign w_op    = fifo_op_e'({w_wrAcc, w_rdAcc});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_rdValid   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_rdValid   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrAcc) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_rdAcc) r_rdPtr <= r_rdPtr + PTR_ONE;
      case (w_op)
        OP_WRITE: r_count <= r_count + CNT_ONE;
        OP_READ:  r_count <= r_count - CNT_ONE;
        default:  r_count <= r_count;
      endcase
      r_rdValid <= w_rdAcc;
      if (bus.wr_en && w_full && !w_rdAcc) r_overflow <= 1'b1;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

`ifdef RES_FIFO_PARITY_EN
  assign w_memWrData    = {^bus.din, bus.din};
  assign bus.dout       = r_rdValid ? w_memRdData[DATA_WIDTH-1:0] : '0;
  assign bus.parity_err = r_rdValid & (^w_memRdData);
`else
  assign w_memWrData    = bus.din;
  assign bus.dout       = r_rdValid ? w_memRdData : '0;
`endif

  res_fifo_mem #(
    .WIDTH      (MEM_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk      (clk),
    .i_wrEn   (w_wrAcc),
    .i_wrAddr (r_wrPtr),
    .i_wrData (w_memWrData),
    .i_rdEn   (w_rdAcc),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_memRdData)
  );

  assign bus.rd_valid     = r_rdValid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= AF_CNT);
  assign bus.almost_empty = (r_count <= AE_CNT);
  assign bus.level        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
